gray_updown_counter: RTL and testbench

Parametrised up/down Gray-code counter with programmable even modulus, synchronous load, optional saturation, and terminal-count flags. It is the general counter used wherever a single-bit-change sequence is needed, such as FIFO pointers, clock-domain-crossing indices and phase sequencers. It supports any even modulus up to 2^WIDTH. The binary and Gray outputs are always coherent within the same cycle.

---
 rtl/gray_pkg.sv | 32 +++
 rtl/gray_updown_counter.sv | 95 +++++++++
 tb/tb_gray_updown_counter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - Gray-code helpers and elaboration checks shared by counters and FIFO pointers
`ifndef GRAY_PKG_ASSERT
`define GRAY_PKG_ASSERT(label, cond, msg) \
  if (!(cond)) begin : label \
    $fatal(1, msg); \
  end
`endif

package gray_pkg;

  localparam int MAX_WIDTH = 16;
  typedef logic [MAX_WIDTH-1:0] word_t;

  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Centres a reduced even modulus in the reflected code so the last and first codes differ in the MSB only.
  function automatic int gray_offset(input int width, input int modulus);
    return ((1 << width) - modulus) / 2;
  endfunction

endpackage

// File: rtl/gray_updown_counter.sv
// rtl/gray_updown_counter.sv - up/down Gray counter with even modulus, load, saturation and flags
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 2 ** WIDTH,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             at_min,
  output logic             at_max,
  output logic             load_err
);

  `GRAY_PKG_ASSERT(g_chk_width, (WIDTH >= 2) && (WIDTH <= MAX_WIDTH), "gray_updown_counter: WIDTH must be 2..16")
  `GRAY_PKG_ASSERT(g_chk_even, (MODULUS % 2) == 0, "gray_updown_counter: MODULUS must be even")
  `GRAY_PKG_ASSERT(g_chk_range, (MODULUS >= 2) && (MODULUS <= (2 ** WIDTH)), "gray_updown_counter: MODULUS out of range")

  localparam logic [WIDTH:0]   LAST       = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] OFFSET     = WIDTH'(gray_offset(WIDTH, MODULUS));
  localparam logic [WIDTH-1:0] RESET_GRAY = WIDTH'(bin2gray(word_t'(OFFSET)));

  logic [WIDTH:0]   cur;
  logic [WIDTH:0]   nxt;
  logic [WIDTH-1:0] nxt_idx;
  logic [WIDTH-1:0] nxt_gray;
  logic             nxt_wrap;
  logic             nxt_err;

  // Index math carries one spare bit so comparisons against MODULUS-1 never alias.
  always_comb begin
    cur      = {1'b0, binary};
    nxt      = cur;
    nxt_wrap = 1'b0;
    nxt_err  = 1'b0;
    if (load) begin
      if ({1'b0, load_val} > LAST) begin
        nxt     = LAST;
        nxt_err = 1'b1;
      end else begin
        nxt = {1'b0, load_val};
      end
    end else if (en) begin
      if (up) begin
        if (cur == LAST) begin
          if (!SATURATE) begin
            nxt      = '0;
            nxt_wrap = 1'b1;
          end
        end else begin
          nxt = cur + 1'b1;
        end
      end else begin
        if (cur == '0) begin
          if (!SATURATE) begin
            nxt      = LAST;
            nxt_wrap = 1'b1;
          end
        end else begin
          nxt = cur - 1'b1;
        end
      end
    end
    nxt_idx  = nxt[WIDTH-1:0] + OFFSET;
    nxt_gray = WIDTH'(bin2gray(word_t'(nxt_idx)));
  end

  // Gray is registered from the next index so it lands on the same edge as binary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      binary   <= '0;
      gray     <= RESET_GRAY;
      wrap     <= 1'b0;
      at_min   <= 1'b1;
      at_max   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      binary   <= nxt[WIDTH-1:0];
      gray     <= nxt_gray;
      wrap     <= nxt_wrap;
      at_min   <= (nxt == '0);
      at_max   <= (nxt == LAST);
      load_err <= nxt_err;
    end
  end

endmodule

// File: tb/tb_gray_updown_counter.sv
// tb/tb_gray_updown_counter.sv - directed bench for wrapping, reduced-modulus and saturating counters
module tb_gray_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en [3];
  logic       up [3];
  logic       load [3];
  logic [3:0] lv [3];
  logic [3:0] bin [3];
  logic [3:0] gry [3];
  logic       wrp [3];
  logic       mn [3];
  logic       mx [3];
  logic       le [3];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  gray_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_full (
    .clk(clk), .reset(reset), .en(en[0]), .up(up[0]), .load(load[0]), .load_val(lv[0]),
    .binary(bin[0]), .gray(gry[0]), .wrap(wrp[0]), .at_min(mn[0]), .at_max(mx[0]), .load_err(le[0])
  );

  gray_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_mod10 (
    .clk(clk), .reset(reset), .en(en[1]), .up(up[1]), .load(load[1]), .load_val(lv[1]),
    .binary(bin[1]), .gray(gry[1]), .wrap(wrp[1]), .at_min(mn[1]), .at_max(mx[1]), .load_err(le[1])
  );

  gray_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .en(en[2]), .up(up[2]), .load(load[2]), .load_val(lv[2]),
    .binary(bin[2]), .gray(gry[2]), .wrap(wrp[2]), .at_min(mn[2]), .at_max(mx[2]), .load_err(le[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] g16 [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                           4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
  logic [3:0] g10 [10] = '{4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC, 4'hD, 4'hF, 4'hE, 4'hA};

  initial begin
    logic [3:0] prev;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      en[k] = 1'b0; up[k] = 1'b1; load[k] = 1'b0; lv[k] = 4'd0;
    end
    step();
    chk("rst_bin_full", bin[0], 0);
    chk("rst_gray_full", gry[0], 4'b0000);
    chk("rst_min_full", mn[0], 1);
    chk("rst_max_full", mx[0], 0);
    chk("rst_wrap_full", wrp[0], 0);
    chk("rst_lerr_full", le[0], 0);
    chk("rst_gray_mod10", gry[1], 4'b0010);
    chk("rst_gray_sat", gry[2], 4'b0000);
    reset = 1'b0;

    // Full-range walk: 16 steps return to zero with one wrap pulse.
    en[0] = 1'b1;
    prev = gry[0];
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("walk_bin", bin[0], i % 16);
      chk("walk_gray", gry[0], g16[i%16]);
      chk("walk_onebit", $countones(gry[0] ^ prev), 1);
      chk("walk_wrap", wrp[0], (i == 16) ? 1 : 0);
      chk("walk_max", mx[0], (i == 15) ? 1 : 0);
      prev = gry[0];
    end
    en[0] = 1'b0;

    // Modulus 10 up-count to the top, then wrap.
    en[1] = 1'b1; up[1] = 1'b1;
    prev = gry[1];
    for (int i = 1; i <= 9; i++) begin
      step();
      chk("m10_bin", bin[1], i);
      chk("m10_gray", gry[1], g10[i]);
      chk("m10_onebit", $countones(gry[1] ^ prev), 1);
      chk("m10_wrap", wrp[1], 0);
      prev = gry[1];
    end
    chk("m10_top_gray", gry[1], 4'b1010);
    chk("m10_top_max", mx[1], 1);
    step();
    chk("m10_wrap_bin", bin[1], 0);
    chk("m10_wrap_gray", gry[1], 4'b0010);
    chk("m10_wrap_pulse", wrp[1], 1);
    chk("m10_wrap_min", mn[1], 1);

    // Down from zero, then one step back up.
    up[1] = 1'b0;
    step();
    chk("m10_dn_bin", bin[1], 9);
    chk("m10_dn_gray", gry[1], 4'b1010);
    chk("m10_dn_wrap", wrp[1], 1);
    up[1] = 1'b1;
    step();
    chk("m10_turn_bin", bin[1], 0);
    chk("m10_turn_gray", gry[1], 4'b0010);
    chk("m10_turn_wrap", wrp[1], 1);
    en[1] = 1'b0;
    step();
    chk("m10_hold_bin", bin[1], 0);
    chk("m10_hold_wrap", wrp[1], 0);

    // Saturating counter pinned at both ends.
    load[2] = 1'b1; lv[2] = 4'd14;
    step();
    chk("sat_load14", bin[2], 14);
    load[2] = 1'b0; en[2] = 1'b1; up[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sat_up_bin", bin[2], 15);
      chk("sat_up_max", mx[2], 1);
      chk("sat_up_wrap", wrp[2], 0);
    end
    chk("sat_top_gray", gry[2], 4'b1000);
    en[2] = 1'b0; load[2] = 1'b1; lv[2] = 4'd1;
    step();
    chk("sat_load1", bin[2], 1);
    load[2] = 1'b0; en[2] = 1'b1; up[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_dn_bin", bin[2], 0);
      chk("sat_dn_min", mn[2], 1);
      chk("sat_dn_wrap", wrp[2], 0);
    end
    en[2] = 1'b0;

    // Loads on modulus 10: in-range load beats en, out-of-range clamps.
    load[1] = 1'b1; lv[1] = 4'd5; en[1] = 1'b1; up[1] = 1'b1;
    step();
    chk("ld5_bin", bin[1], 5);
    chk("ld5_gray", gry[1], 4'b1100);
    chk("ld5_err", le[1], 0);
    chk("ld5_wrap", wrp[1], 0);
    lv[1] = 4'd12;
    step();
    chk("ld12_bin", bin[1], 9);
    chk("ld12_gray", gry[1], 4'b1010);
    chk("ld12_err", le[1], 1);
    chk("ld12_max", mx[1], 1);
    load[1] = 1'b0; en[1] = 1'b0;
    step();
    chk("ld12_err_drop", le[1], 0);
    chk("ld12_hold", bin[1], 9);

    // Asynchronous reset in the middle of a count.
    load[0] = 1'b1; lv[0] = 4'd7;
    step();
    chk("pre_rst_bin", bin[0], 7);
    load[0] = 1'b0; en[0] = 1'b1; up[0] = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_bin", bin[0], 0);
    chk("async_rst_gray", gry[0], 4'b0000);
    chk("async_rst_min", mn[0], 1);
    chk("async_rst_mod10_gray", gry[1], 4'b0010);
    step();
    chk("rst_held_bin", bin[0], 0);
    reset = 1'b0;
    step();
    chk("resume_bin", bin[0], 1);
    chk("resume_gray", gry[0], 4'b0001);
    chk("resume_min", mn[0], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
